// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard controller with vector memory lane sequencer (optional perf counters: HAZARD_PERF_EN)
module hazard_unit #(
  parameter int VLANES = 8,
  parameter int REGW   = 5,
  parameter int PCNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            memwriteM,
  input  logic            memdataM,
  input  logic [1:0]      branchD,
  input  logic            pcsrcD,
  input  logic            jumpD,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            flushD,
  output logic            flushE,
  output logic            flushW,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic [7:0]      lane_idx,
  output logic            vmem_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [PCNT_W-1:0] stall_cycles,
  output logic [PCNT_W-1:0] flush_count
`endif
);

  typedef enum logic {IDLE, VSEQ} state_t;

  localparam logic [7:0] LAST_LANE = 8'(VLANES - 1);

  state_t     state_q, state_d;
  logic [7:0] lane_cnt_q, lane_cnt_d;

  logic       vstart, vstall, lwstall, brstall;
  logic       lane_busy;
  logic [7:0] lane_cur;
  logic       stall_fd;
  logic       active;

  // Register tag 0 is hardwired zero, so it never creates a dependency.
  function automatic logic tag_hit(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Vector sequencer state register; reset abandons any lanes still outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lane_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

  // Vector sequencer next state: lane 0 is issued from IDLE, the rest from VSEQ.
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    vstall     = 1'b0;
    lane_cur   = 8'd0;
    lane_busy  = 1'b0;
    vstart     = memdataM & (memwriteM | memtoregM);
    case (state_q)
      IDLE: begin
        if (vstart && (VLANES > 1)) begin
          vstall     = 1'b1;
          state_d    = VSEQ;
          lane_cnt_d = 8'd1;
        end
      end
      VSEQ: begin
        lane_busy = 1'b1;
        lane_cur  = lane_cnt_q;
        if (lane_cnt_q == LAST_LANE) begin
          state_d    = IDLE;
          lane_cnt_d = 8'd0;
        end else begin
          vstall     = 1'b1;
          lane_cnt_d = lane_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        lane_cnt_d = 8'd0;
      end
    endcase
  end

  // Load-use and branch-compare dependency detection.
  always_comb begin
    lwstall = memtoregE & (tag_hit(rtE, rsD) | tag_hit(rtE, rtD));
    brstall = (branchD != 2'b00) &
              ((regwriteE & (tag_hit(writeregE, rsD) | tag_hit(writeregE, rtD))) |
               (memtoregM & (tag_hit(writeregM, rsD) | tag_hit(writeregM, rtD))));
  end

  // Stall, flush, forward and lane outputs; all forced low while reset is held.
  always_comb begin
    active    = ~reset;
    stall_fd  = vstall | lwstall | brstall;
    stallF    = active & stall_fd;
    stallD    = active & stall_fd;
    stallE    = active & vstall;
    stallM    = active & vstall;
    flushW    = active & vstall;
    flushE    = active & (lwstall | brstall) & ~vstall;
    flushD    = active & (pcsrcD | jumpD) & ~stall_fd;
    forwardAD = active & regwriteM & tag_hit(writeregM, rsD);
    forwardBD = active & regwriteM & tag_hit(writeregM, rtD);
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (active) begin
      if (regwriteM && tag_hit(writeregM, rsE))      forwardAE = 2'b10;
      else if (regwriteW && tag_hit(writeregW, rsE)) forwardAE = 2'b01;
      if (regwriteM && tag_hit(writeregM, rtE))      forwardBE = 2'b10;
      else if (regwriteW && tag_hit(writeregW, rtE)) forwardBE = 2'b01;
    end
    lane_idx  = active ? lane_cur : 8'd0;
    vmem_busy = active & lane_busy;
  end

`ifdef HAZARD_PERF_EN
  logic [PCNT_W-1:0] stall_cycles_q, flush_count_q;

  // Saturating counters of stalled decode cycles and flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stallD && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 1'b1;
      if ((flushD || flushE) && (flush_count_q != '1)) flush_count_q <= flush_count_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed vector bench for hazard_unit (perf counters checked when HAZARD_PERF_EN is defined)
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM, memdataM;
  logic [1:0] branchD;
  logic       pcsrcD, jumpD;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic       forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic [7:0] lane_idx;
  logic       vmem_busy;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  hazard_unit #(.VLANES(8), .REGW(5), .PCNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .memwriteM(memwriteM), .memdataM(memdataM),
    .branchD(branchD), .pcsrcD(pcsrcD), .jumpD(jumpD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .lane_idx(lane_idx), .vmem_busy(vmem_busy)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       rwE, rwM, rwW, mtrE, mtrM, mwM, mdM;
    logic [1:0] br;
    logic       pc, jp;
    logic       st, fd, fe, fad, fbd;
    logic [1:0] fae, fbe;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
    memwriteM = 0; memdataM = 0; branchD = 0; pcsrcD = 0; jumpD = 0;
  endtask

  task automatic apply(input vec_t v);
    rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    writeregE = v.wE; writeregM = v.wM; writeregW = v.wW;
    regwriteE = v.rwE; regwriteM = v.rwM; regwriteW = v.rwW;
    memtoregE = v.mtrE; memtoregM = v.mtrM; memwriteM = v.mwM; memdataM = v.mdM;
    branchD = v.br; pcsrcD = v.pc; jumpD = v.jp;
  endtask

  function automatic logic [12:0] comb_outs();
    return {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
            forwardAD, forwardBD, forwardAE, forwardBE};
  endfunction

  function automatic logic [13:0] vec_outs();
    return {lane_idx, stallF, stallD, stallE, stallM, flushW, vmem_busy};
  endfunction

  initial begin
    tv[0]  = '{default: 0};
    tv[1]  = '{mtrE: 1, rtE: 5, rsD: 5, st: 1, fe: 1, default: 0};
    tv[2]  = '{rwM: 1, rwW: 1, wM: 3, wW: 3, rsE: 3, fae: 2'b10, default: 0};
    tv[3]  = '{rwM: 1, rwW: 1, wM: 0, wW: 0, rsE: 0, rtE: 0, default: 0};
    tv[4]  = '{rwM: 1, wM: 6, rwW: 1, wW: 4, rsE: 4, rtE: 4, fae: 2'b01, fbe: 2'b01, default: 0};
    tv[5]  = '{rwM: 1, wM: 9, rtE: 9, fbe: 2'b10, default: 0};
    tv[6]  = '{rwM: 0, wM: 3, rwW: 1, wW: 3, rsE: 3, fae: 2'b01, default: 0};
    tv[7]  = '{br: 1, rwE: 1, wE: 7, rsD: 7, st: 1, fe: 1, default: 0};
    tv[8]  = '{br: 1, rwE: 1, wE: 7, rsD: 7, pc: 1, st: 1, fe: 1, default: 0};
    tv[9]  = '{br: 1, rwM: 1, wM: 7, rsD: 7, pc: 1, fad: 1, fd: 1, default: 0};
    tv[10] = '{br: 2, mtrM: 1, rwM: 1, wM: 8, rtD: 8, fbd: 1, st: 1, fe: 1, default: 0};
    tv[11] = '{jp: 1, fd: 1, default: 0};
    tv[12] = '{mtrE: 1, rtE: 0, rsD: 0, default: 0};
    tv[13] = '{br: 0, rwE: 1, wE: 7, rsD: 7, default: 0};
    tv[14] = '{mtrE: 1, rtE: 12, rtD: 12, jp: 1, st: 1, fe: 1, default: 0};

    clear_inputs();
    reset = 1'b1;
    #1;
    chk("reset_outputs", {18'd0, vec_outs()}, 32'd0);
    chk("reset_comb", {19'd0, comb_outs()}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      apply(tv[i]);
      #1;
      chk($sformatf("vec%0d", i), {19'd0, comb_outs()},
          {19'd0, tv[i].st, tv[i].st, 1'b0, 1'b0, tv[i].fd, tv[i].fe, 1'b0,
           tv[i].fad, tv[i].fbd, tv[i].fae, tv[i].fbe});
      chk($sformatf("vec%0d_lane", i), {18'd0, vec_outs()} & 32'h3fc1, 32'd0);
    end

    // Load-use: one bubble, then the load sits in W and feeds E.
    @(negedge clk);
    clear_inputs();
    memtoregE = 1; rtE = 5; rsD = 5; regwriteE = 1; writeregE = 5;
    #1;
    chk("lu_stall", {29'd0, stallF, stallD, flushE}, 32'd7);
    @(negedge clk);
    clear_inputs();
    rsE = 5; regwriteW = 1; writeregW = 5;
    #1;
    chk("lu_fwd", {30'd0, forwardAE}, 32'd1);
    chk("lu_nostall", {29'd0, stallF, stallD, flushE}, 32'd0);

    // Branch: one stall cycle, then producer in M feeds the compare.
    @(negedge clk);
    clear_inputs();
    branchD = 1; regwriteE = 1; writeregE = 7; rsD = 7;
    #1;
    chk("br_stall", {30'd0, stallD, flushE}, 32'd3);
    @(negedge clk);
    clear_inputs();
    branchD = 1; regwriteM = 1; writeregM = 7; rsD = 7; pcsrcD = 1;
    #1;
    chk("br_fwd_flush", {29'd0, forwardAD, flushD, stallD}, 32'd6);

    // Full 8-lane vector store; a load-use at lane 2 must not produce flushE.
    @(negedge clk);
    clear_inputs();
    memdataM = 1; memwriteM = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin memtoregE = 1; rtE = 5; rsD = 5; end
      if (i == 3) begin memtoregE = 0; rtE = 0; rsD = 0; end
      if (i == 7) begin memdataM = 0; memwriteM = 0; end
      #1;
      chk($sformatf("vlane%0d", i), {18'd0, vec_outs()},
          {18'd0, 8'(i), (i < 7), (i < 7), (i < 7), (i < 7), (i < 7), (i > 0)});
      chk($sformatf("vlane%0d_flushE", i), {31'd0, flushE}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("vec_done", {18'd0, vec_outs()}, 32'd0);

    // Reset in the middle of a sequence, then restart from lane 0.
    @(negedge clk);
    memdataM = 1; memtoregM = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_lane3", {24'd0, lane_idx}, 32'd3);
    memtoregE = 1; rtE = 5; rsD = 5; jumpD = 1; regwriteM = 1; writeregM = 5; rsE = 5;
    reset = 1'b1;
    #1;
    chk("rst_mid_vec", {18'd0, vec_outs()}, 32'd0);
    chk("rst_mid_comb", {19'd0, comb_outs()}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    memtoregE = 0; rtE = 0; rsD = 0; jumpD = 0; regwriteM = 0; writeregM = 0; rsE = 0;
    #1;
    chk("restart_lane0", {18'd0, vec_outs()}, {18'd0, 8'd0, 5'b11111, 1'b0});
    @(negedge clk);
    memdataM = 0; memtoregM = 0;
    #1;
    chk("restart_lane1", {18'd0, vec_outs()}, {18'd0, 8'd1, 5'b11111, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_idle", {18'd0, vec_outs()}, 32'd0);

`ifdef HAZARD_PERF_EN
    // 8-lane op gives 7 stalled cycles; one load-use adds a stall and a flush.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    memdataM = 1; memwriteM = 1;
    repeat (7) @(negedge clk);
    memdataM = 0; memwriteM = 0;
    @(negedge clk);
    memtoregE = 1; rtE = 5; rsD = 5;
    @(negedge clk);
    clear_inputs();
    #1;
    chk("perf_stall_cycles", {16'd0, stall_cycles}, 32'd8);
    chk("perf_flush_count", {16'd0, flush_count}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
